seven_seg_scan_ctrl: RTL and testbench

Time-multiplexing scheduler for the 4-digit seven-segment display on the lab board. It rotates the four active-low anodes and presents one 4-bit operand per digit (A, B, A+B, A-B) to the hex decoder.
- Inserts a programmable blanking gap before each digit to suppress ghosting.
- Snapshots all four operands once per frame so a displayed frame never mixes old and new values.
- Sits between the arithmetic datapath and the segment decoder/board pins.

---
 rtl/seven_seg_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler: per-slot blanking gap, active-low anodes,
// and a per-frame operand snapshot so one frame never mixes old and new values.
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit_mask,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] AplusB,
    input  logic [3:0] AminusB,
    output logic [3:0] anode,
    output logic [3:0] selected_sig,
    output logic [1:0] digit_idx,
    output logic       frame_start
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [3:0]    DARK       = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      anode_q, anode_d;
    logic [3:0]      sel_q, sel_d;
    logic            fs_q, fs_d;
    logic [3:0][3:0] snap_q, snap_d;

    logic [1:0]      idx_nxt;
    logic [3:0][3:0] snap_new;

    // Digit 3 (leftmost) shows A, digit 0 (rightmost) shows A-B.
    assign snap_new = {A, B, AplusB, AminusB};
    assign idx_nxt  = idx_q + 2'd1;

    function automatic logic [3:0] lit_pattern(input logic [3:0] mask, input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return mask[idx] ? ~onehot : DARK;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        anode_d = anode_q;
        sel_d   = sel_q;
        fs_d    = 1'b0;
        snap_d  = snap_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
            anode_d = DARK;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    anode_d = DARK;
                    fs_d    = 1'b1;
                    snap_d  = snap_new;
                    sel_d   = AminusB;
                end
                BLANK: begin
                    cnt_d   = cnt_q + CW'(1);
                    anode_d = DARK;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        anode_d = lit_pattern(digit_mask, idx_q);
                    end
                end
                SHOW: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_nxt;
                        anode_d = DARK;
                        if (idx_q == 2'd3) begin
                            // Frame wrap: take the fresh snapshot at the same edge it is shown.
                            snap_d = snap_new;
                            sel_d  = AminusB;
                            fs_d   = 1'b1;
                        end else begin
                            sel_d  = snap_q[idx_nxt];
                        end
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        anode_d = lit_pattern(digit_mask, idx_q);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    anode_d = DARK;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            anode_q <= DARK;
            sel_q   <= 4'd0;
            fs_q    <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            sel_q   <= sel_d;
            fs_q    <= fs_d;
            snap_q  <= snap_d;
        end
    end

    assign anode        = anode_q;
    assign selected_sig = sel_q;
    assign digit_idx    = idx_q;
    assign frame_start  = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a time-based reference model queues the
// expected outputs per cycle, a monitor pops and compares them plus display invariants.
module tb_seven_seg_scan_ctrl;

    localparam int RD  = 8;
    localparam int BLK = 2;
    localparam int FRAME = 4 * RD;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] digit_mask;
    logic [3:0] A, B, AplusB, AminusB;
    logic [3:0] anode;
    logic [3:0] selected_sig;
    logic [1:0] digit_idx;
    logic       frame_start;

    seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BLK)) dut (
        .clk(clk), .reset(reset), .enable(enable), .digit_mask(digit_mask),
        .A(A), .B(B), .AplusB(AplusB), .AminusB(AminusB),
        .anode(anode), .selected_sig(selected_sig), .digit_idx(digit_idx),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [3:0] sel;
        logic [1:0] idx;
        logic       fs;
        bit         chk_sel;
        bit         run;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: position in the frame is pure arithmetic on cycles since enable.
    initial begin : model
        bit         m_run;
        int         m_t;
        logic [3:0] m_snap [4];
        logic [3:0] m_sel;
        logic [3:0] onehot;
        int         slot, ph;
        exp_t       e;
        m_run = 0; m_t = 0; m_sel = 4'd0;
        foreach (m_snap[i]) m_snap[i] = 4'd0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_run = 0;
                foreach (m_snap[i]) m_snap[i] = 4'd0;
                m_sel = 4'd0;
                e = '{an: 4'hF, sel: 4'h0, idx: 2'd0, fs: 1'b0, chk_sel: 1, run: 0};
            end else if (!enable) begin
                m_run = 0;
                e = '{an: 4'hF, sel: m_sel, idx: 2'd0, fs: 1'b0, chk_sel: 0, run: 0};
            end else begin
                if (!m_run) begin
                    m_run = 1;
                    m_t   = 0;
                end else begin
                    m_t++;
                end
                slot = (m_t / RD) % 4;
                ph   = m_t % RD;
                if (m_t % FRAME == 0) begin
                    m_snap[3] = A; m_snap[2] = B; m_snap[1] = AplusB; m_snap[0] = AminusB;
                end
                m_sel  = m_snap[slot];
                onehot = 4'b0001 << slot;
                e.an   = (ph < BLK || !digit_mask[slot]) ? 4'hF : ~onehot;
                e.sel  = m_sel;
                e.idx  = 2'(slot);
                e.fs   = (m_t % FRAME == 0);
                e.chk_sel = 1;
                e.run  = 1;
            end
            q.push_back(e);
            started = 1;
        end
    end

    initial begin : monitor
        exp_t e;
        int   zeros, digit, last_digit, blank_run, last_fs;
        bit   have_last, fs_valid;
        have_last = 0; fs_valid = 0; blank_run = 0; last_digit = 0; last_fs = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() == 0) begin
                if (started) chk("queue_underflow", 0, 1);
            end else begin
                e = q.pop_front();
                chk("anode", anode, e.an);
                chk("digit_idx", digit_idx, e.idx);
                chk("frame_start", frame_start, e.fs);
                if (e.chk_sel) chk("selected_sig", selected_sig, e.sel);
                zeros = 0; digit = 0;
                for (int i = 0; i < 4; i++) if (anode[i] !== 1'b1) begin zeros++; digit = i; end
                chk("anode_onehot_low", zeros <= 1, 1);
                if (zeros != 0) begin
                    if (have_last && digit != last_digit) chk("blank_gap", blank_run >= BLK, 1);
                    last_digit = digit; have_last = 1; blank_run = 0;
                end else begin
                    blank_run++;
                end
                if (!e.run) fs_valid = 0;
                else if (frame_start === 1'b1) begin
                    if (fs_valid) chk("frame_period", cyc - last_fs, FRAME);
                    last_fs = cyc; fs_valid = 1;
                end
            end
        end
    end

    initial begin : stim
        bit found;
        reset = 1; enable = 1; digit_mask = 4'hF;
        A = 4'd3; B = 4'd5; AplusB = 4'd8; AminusB = 4'd14;
        repeat (3) @(negedge clk);
        reset = 0;
        // A changes during digit-1 slot: invisible until the next frame.
        repeat (10) @(negedge clk);
        A = 4'd9;
        repeat (60) @(negedge clk);
        digit_mask = 4'b1011;
        repeat (40) @(negedge clk);
        digit_mask = 4'hF;
        found = 0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(negedge clk);
            if (digit_idx == 2'd2 && anode == 4'b1011) found = 1;
        end
        chk("wait_digit2_show", found, 1);
        enable = 0;
        repeat (3) @(negedge clk);
        A = 4'd7; AminusB = 4'd1;
        enable = 1;
        repeat (33) @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (!enable && $urandom_range(0, 7) == 0) enable = 1;
            else if (enable && $urandom_range(0, 299) == 0) enable = 0;
            if ($urandom_range(0, 39) == 0) digit_mask = 4'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                A = 4'($urandom); B = 4'($urandom);
                AplusB = A + B; AminusB = A - B;
            end
            reset = ($urandom_range(0, 2999) == 0);
        end
        reset = 0;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
